// File: rtl/ozone.sv
// ozone: minimal in-order AArch64-subset core (MOVZ, ADDS shifted-register, HLT).
//
// Fetches 64-byte lines (16 instructions) over the lower-cache (LC) port and
// retires one instruction per cycle while the current line is resident.
// Register file is 31 x 64-bit; index 31 reads as zero and ignores writes.
//
// Ports:
//   clk_in        clock
//   rst_N         asynchronous active-low reset
//   cs_N_in       chip select (reserved, ignored)
//   start         begin execution at start_pc (sampled only in IDLE)
//   start_pc      initial program counter
//   lc_valid_in   LC response valid
//   lc_ready_out  core ready to take an LC response (FETCH_WAIT only)
//   lc_addr_in    line address of the response
//   lc_value_in   response line data (512 bits)
//   lc_valid_out  core request valid
//   lc_ready_in   LC ready to take the request
//   lc_addr_out   request line address (bits 5:0 zero)
//   lc_value_out  write data (register dump only)
//   lc_we_out     request is a write
//
// Optional feature macro: OZONE_DUMP_EN. When defined, HLT enters a DUMP
// state that writes x0..x7 as one line to 64'hFFFF_FFFF_FFFF_FFC0 before
// halting. When undefined, HLT halts directly and lc_we_out/lc_value_out are 0.

module ozone (
    input  logic         clk_in,
    input  logic         rst_N,
    input  logic         cs_N_in,
    input  logic         start,
    input  logic [63:0]  start_pc,
    input  logic         lc_valid_in,
    output logic         lc_ready_out,
    input  logic [63:0]  lc_addr_in,
    input  logic [511:0] lc_value_in,
    output logic         lc_valid_out,
    input  logic         lc_ready_in,
    output logic [63:0]  lc_addr_out,
    output logic [511:0] lc_value_out,
    output logic         lc_we_out
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH_REQ,
        S_FETCH_WAIT,
        S_EXEC,
        S_HALT,
        S_DUMP
    } state_t;

    state_t       r_state;
    logic [63:0]  r_pc;
    logic [63:0]  r_regs [0:30];
    logic [3:0]   r_nzcv;
    logic [511:0] r_line;
    logic [57:0]  r_tag;
    logic         r_line_vld;
    logic         r_lc_valid;
    logic         r_lc_ready;
    logic [63:0]  r_lc_addr;

    // Chip select is reserved; folded into a sink so it is visibly ignored.
    logic w_unused;
    assign w_unused = cs_N_in;

    // Decode of the instruction at the current pc within the buffered line.
    logic [31:0] w_insn;
    logic        w_is_movz;
    logic        w_is_adds;
    logic        w_is_hlt;
    logic [4:0]  w_rd;
    logic [4:0]  w_rn;
    logic [4:0]  w_rm;
    logic [5:0]  w_sh;
    logic [63:0] w_rn_val;
    logic [63:0] w_rm_val;
    logic [63:0] w_movz_val;
    logic [63:0] w_opb;
    logic [64:0] w_sum;
    logic        w_ovf;
    logic [63:0] w_pc_next;
    logic        w_leave;

    always_comb begin
        w_insn     = r_line[{r_pc[5:2], 5'b00000} +: 32];
        w_is_movz  = (w_insn[31:23] == 9'b110100101);
        w_is_adds  = (w_insn[31:21] == 11'b10101011000);
        w_is_hlt   = (w_insn[31:21] == 11'b11010100010);
        w_rd       = w_insn[4:0];
        w_rn       = w_insn[9:5];
        w_rm       = w_insn[20:16];
        w_sh       = w_insn[15:10];
        w_rn_val   = (w_rn == 5'd31) ? 64'd0 : r_regs[w_rn];
        w_rm_val   = (w_rm == 5'd31) ? 64'd0 : r_regs[w_rm];
        w_movz_val = {48'd0, w_insn[20:5]} << {w_insn[22:21], 4'b0000};
        w_opb      = w_rm_val << w_sh;
        w_sum      = {1'b0, w_rn_val} + {1'b0, w_opb};
        // Signed overflow: operands agree in sign, result does not.
        w_ovf      = (w_rn_val[63] == w_opb[63]) && (w_sum[63] != w_rn_val[63]);
        w_pc_next  = r_pc + 64'd4;
        w_leave    = !r_line_vld || (w_pc_next[63:6] != r_tag);
    end

`ifdef OZONE_DUMP_EN
    logic         r_lc_we;
    logic [511:0] r_lc_value;
    assign lc_we_out    = r_lc_we;
    assign lc_value_out = r_lc_value;
`else
    assign lc_we_out    = 1'b0;
    assign lc_value_out = '0;
`endif

    assign lc_valid_out = r_lc_valid;
    assign lc_ready_out = r_lc_ready;
    assign lc_addr_out  = r_lc_addr;

    always_ff @(posedge clk_in or negedge rst_N) begin
        if (!rst_N) begin
            r_state    <= S_IDLE;
            r_pc       <= '0;
            r_nzcv     <= '0;
            r_line     <= '0;
            r_tag      <= '0;
            r_line_vld <= 1'b0;
            r_lc_valid <= 1'b0;
            r_lc_ready <= 1'b0;
            r_lc_addr  <= '0;
            for (int i = 0; i < 31; i++) begin
                r_regs[i] <= '0;
            end
`ifdef OZONE_DUMP_EN
            r_lc_we    <= 1'b0;
            r_lc_value <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_pc       <= start_pc;
                        r_lc_addr  <= {start_pc[63:6], 6'b000000};
                        r_lc_valid <= 1'b1;
                        r_state    <= S_FETCH_REQ;
                    end
                end

                S_FETCH_REQ: begin
                    if (lc_ready_in) begin
                        r_lc_valid <= 1'b0;
                        r_lc_ready <= 1'b1;
                        r_state    <= S_FETCH_WAIT;
                    end
                end

                S_FETCH_WAIT: begin
                    // Responses for another line are consumed and discarded.
                    if (lc_valid_in && (lc_addr_in == r_lc_addr)) begin
                        r_line     <= lc_value_in;
                        r_tag      <= lc_addr_in[63:6];
                        r_line_vld <= 1'b1;
                        r_lc_ready <= 1'b0;
                        r_state    <= S_EXEC;
                    end
                end

                S_EXEC: begin
                    if (w_is_hlt) begin
`ifdef OZONE_DUMP_EN
                        r_lc_valid <= 1'b1;
                        r_lc_we    <= 1'b1;
                        r_lc_addr  <= 64'hFFFF_FFFF_FFFF_FFC0;
                        r_lc_value <= {r_regs[7], r_regs[6], r_regs[5], r_regs[4],
                                       r_regs[3], r_regs[2], r_regs[1], r_regs[0]};
                        r_state    <= S_DUMP;
`else
                        r_state    <= S_HALT;
`endif
                    end else begin
                        if (w_is_movz && (w_rd != 5'd31)) begin
                            r_regs[w_rd] <= w_movz_val;
                        end
                        if (w_is_adds) begin
                            if (w_rd != 5'd31) begin
                                r_regs[w_rd] <= w_sum[63:0];
                            end
                            r_nzcv <= {w_sum[63], (w_sum[63:0] == 64'd0), w_sum[64], w_ovf};
                        end
                        r_pc <= w_pc_next;
                        if (w_leave) begin
                            r_lc_addr  <= {w_pc_next[63:6], 6'b000000};
                            r_lc_valid <= 1'b1;
                            r_state    <= S_FETCH_REQ;
                        end
                    end
                end

`ifdef OZONE_DUMP_EN
                S_DUMP: begin
                    if (lc_ready_in) begin
                        r_lc_valid <= 1'b0;
                        r_lc_we    <= 1'b0;
                        r_lc_addr  <= '0;
                        r_lc_value <= '0;
                        r_state    <= S_HALT;
                    end
                end
`endif

                S_HALT: begin
                    r_state <= S_HALT;
                end

                default: begin
                    r_state <= S_HALT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ozone.sv
module tb_ozone;

    logic         clk_in;
    logic         rst_N;
    logic         cs_N_in;
    logic         start;
    logic [63:0]  start_pc;
    logic         lc_valid_in;
    logic         lc_ready_out;
    logic [63:0]  lc_addr_in;
    logic [511:0] lc_value_in;
    logic         lc_valid_out;
    logic         lc_ready_in;
    logic [63:0]  lc_addr_out;
    logic [511:0] lc_value_out;
    logic         lc_we_out;

    ozone dut (
        .clk_in       (clk_in),
        .rst_N        (rst_N),
        .cs_N_in      (cs_N_in),
        .start        (start),
        .start_pc     (start_pc),
        .lc_valid_in  (lc_valid_in),
        .lc_ready_out (lc_ready_out),
        .lc_addr_in   (lc_addr_in),
        .lc_value_in  (lc_value_in),
        .lc_valid_out (lc_valid_out),
        .lc_ready_in  (lc_ready_in),
        .lc_addr_out  (lc_addr_out),
        .lc_value_out (lc_value_out),
        .lc_we_out    (lc_we_out)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [63:0]  addr;
        logic         we;
        logic [511:0] value;
    } req_t;

    req_t exp_q[$];
    req_t mon_e;
    int   n_vec  = 0;
    int   n_fail = 0;

    localparam logic [31:0] HLT = {11'b11010100010, 21'd0};

    function automatic logic [31:0] movz(input int rd, input int imm, input int hw);
        logic [4:0]  r = rd[4:0];
        logic [15:0] i = imm[15:0];
        logic [1:0]  h = hw[1:0];
        return {9'b110100101, h, i, r};
    endfunction

    function automatic logic [31:0] adds(input int rd, input int rn, input int rm, input int sh);
        logic [4:0] d = rd[4:0];
        logic [4:0] n = rn[4:0];
        logic [4:0] m = rm[4:0];
        logic [5:0] s = sh[5:0];
        return {11'b10101011000, m, s, n, d};
    endfunction

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    // Scoreboard monitor: every request handshake pops one expectation.
    always @(negedge clk_in) begin
        if (rst_N && lc_valid_out && lc_ready_in) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_fail++;
                $display("FAIL unexpected_req: got addr %0h we %0b, want no request", lc_addr_out, lc_we_out);
            end else begin
                mon_e = exp_q.pop_front();
                chk("req_addr", lc_addr_out, mon_e.addr);
                chk("req_we", lc_we_out, mon_e.we);
                chk("req_value", lc_value_out, mon_e.value);
            end
        end
    end

    task automatic push_req(input logic [63:0] a, input logic we, input logic [511:0] v);
        req_t e;
        e.addr = a; e.we = we; e.value = v;
        exp_q.push_back(e);
    endtask

    task automatic push_dump(input logic [63:0] r0, input logic [63:0] r1, input logic [63:0] r2,
                             input logic [63:0] r3, input logic [63:0] r4, input logic [63:0] r5,
                             input logic [63:0] r6, input logic [63:0] r7);
`ifdef OZONE_DUMP_EN
        push_req(64'hFFFF_FFFF_FFFF_FFC0, 1'b1, {r7, r6, r5, r4, r3, r2, r1, r0});
`else
        if (r0 === 64'hx || r7 === 64'hx) $display("dump values undefined");
`endif
    endtask

    task automatic do_reset();
        rst_N = 1'b0; start = 1'b0; lc_valid_in = 1'b0; lc_ready_in = 1'b0;
        repeat (2) @(posedge clk_in);
        #1 rst_N = 1'b1;
    endtask

    // Called at posedge+1. Accept the pending request (bounded wait).
    task automatic take_req(input string nm, input logic [63:0] a);
        for (int i = 0; i < 40; i++) begin
            if (lc_valid_out) break;
            @(posedge clk_in); #1;
        end
        chk(nm, lc_valid_out, 1);
        push_req(a, 1'b0, '0);
        lc_ready_in = 1'b1;
        @(posedge clk_in); #1;
        lc_ready_in = 1'b0;
    endtask

    task automatic send_line(input string nm, input logic [63:0] a, input logic [511:0] d);
        chk(nm, lc_ready_out, 1);
        lc_valid_in = 1'b1; lc_addr_in = a; lc_value_in = d;
        @(posedge clk_in); #1;
        lc_valid_in = 1'b0; lc_addr_in = '0; lc_value_in = '0;
    endtask

    // Run n cycles, granting any request the core raises.
    task automatic run_serve(input int n);
        repeat (n) begin
            lc_ready_in = lc_valid_out;
            @(posedge clk_in); #1;
        end
        lc_ready_in = 1'b0;
    endtask

    task automatic check_halt(input string nm);
        logic [63:0] pc0;
        pc0 = dut.r_pc;
        run_serve(6);
        chk({nm, "_pc_frozen"}, dut.r_pc, pc0);
        chk({nm, "_no_req"}, lc_valid_out, 0);
    endtask

    logic [31:0]  prog [16];
    logic [511:0] line;
    int           cyc;

    function automatic logic [511:0] pack(input logic [31:0] p [16]);
        logic [511:0] l;
        for (int i = 0; i < 16; i++) l[32*i +: 32] = p[i];
        return l;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        cs_N_in = 1'b1; start = 1'b0; start_pc = '0;
        lc_valid_in = 1'b0; lc_addr_in = '0; lc_value_in = '0; lc_ready_in = 1'b0;
        rst_N = 1'b0;
        repeat (5) @(posedge clk_in);
        #1;
        chk("rst_valid", lc_valid_out, 0);
        chk("rst_ready", lc_ready_out, 0);
        chk("rst_addr", lc_addr_out, 0);
        chk("rst_we", lc_we_out, 0);
        chk("rst_value", lc_value_out, 0);
        rst_N = 1'b1;
        repeat (3) begin
            @(posedge clk_in); #1;
            chk("idle_no_req", lc_valid_out, 0);
        end

        // ---- Program A: movz/adds chain ending in HLT ----
        start = 1'b1; start_pc = 64'h0;
        @(posedge clk_in); #1;
        start = 1'b0;
        chk("start_to_req", lc_valid_out, 1);
        chk("req0_addr", lc_addr_out, 0);
        chk("req0_we", lc_we_out, 0);
        repeat (3) begin
            @(posedge clk_in); #1;
            chk("req_held_valid", lc_valid_out, 1);
            chk("req_held_addr", lc_addr_out, 0);
        end
        take_req("reqA", 64'h0);
        chk("wait_ready", lc_ready_out, 1);
        for (int i = 0; i < 16; i++) prog[i] = HLT;
        send_line("ready_wrong", 64'h80, pack(prog));
        chk("drop_stays_wait", lc_ready_out, 1);
        for (int i = 0; i < 16; i++) prog[i] = 32'h0;
        prog[0] = movz(0, 16'hFFFF, 0);
        prog[1] = movz(1, 16'hFFFF, 1);
        prog[2] = movz(2, 16'hFFFF, 3);
        prog[3] = movz(3, 16'hFFFF, 2);
        prog[4] = movz(4, 1, 0);
        prog[5] = adds(5, 0, 1, 0);
        prog[6] = adds(6, 2, 3, 0);
        prog[7] = adds(7, 5, 6, 0);
        prog[8] = adds(8, 4, 7, 0);
        prog[9] = HLT;
        push_dump(64'hFFFF, 64'hFFFF_0000, 64'hFFFF_0000_0000_0000, 64'h0000_FFFF_0000_0000,
                  64'h1, 64'hFFFF_FFFF, 64'hFFFF_FFFF_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF);
        send_line("ready_A", 64'h0, pack(prog));
        run_serve(25);
        chk("A_x3", dut.r_regs[3], 64'h0000_FFFF_0000_0000);
        chk("A_x5", dut.r_regs[5], 64'h0000_0000_FFFF_FFFF);
        chk("A_x6", dut.r_regs[6], 64'hFFFF_FFFF_0000_0000);
        chk("A_x7", dut.r_regs[7], 64'hFFFF_FFFF_FFFF_FFFF);
        chk("A_x8", dut.r_regs[8], 64'h0);
        chk("A_nzcv", dut.r_nzcv, 4'b0110);
        check_halt("A");
        start = 1'b1;
        run_serve(3);
        start = 1'b0;
        chk("A_start_ignored", lc_valid_out, 0);

        // ---- Program B: 16 movz then HLT on the next line ----
        do_reset();
        start = 1'b1; start_pc = 64'h0;
        @(posedge clk_in); #1;
        start = 1'b0;
        take_req("reqB0", 64'h0);
        for (int i = 0; i < 16; i++) prog[i] = movz(i, i + 1, 0);
        send_line("ready_B0", 64'h0, pack(prog));
        cyc = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk_in); #1;
            if (lc_valid_out) begin cyc = k; break; end
        end
        chk("B_refetch_cycles", cyc, 16);
        take_req("reqB1", 64'h40);
        for (int i = 0; i < 16; i++) prog[i] = 32'h0;
        prog[0] = HLT;
        push_dump(64'd1, 64'd2, 64'd3, 64'd4, 64'd5, 64'd6, 64'd7, 64'd8);
        send_line("ready_B1", 64'h40, pack(prog));
        run_serve(10);
        chk("B_x0", dut.r_regs[0], 64'd1);
        chk("B_x7", dut.r_regs[7], 64'd8);
        chk("B_x15", dut.r_regs[15], 64'd16);
        check_halt("B");

        // ---- Reset mid-fetch, then program C: shifts, xzr, overflow ----
        do_reset();
        start = 1'b1; start_pc = 64'h100;
        @(posedge clk_in); #1;
        start = 1'b0;
        chk("C_req_up", lc_valid_out, 1);
        #2 rst_N = 1'b0;
        #1;
        chk("midrst_valid", lc_valid_out, 0);
        chk("midrst_addr", lc_addr_out, 0);
        chk("midrst_ready", lc_ready_out, 0);
        @(posedge clk_in); #1 rst_N = 1'b1;
        start = 1'b1;
        @(posedge clk_in); #1;
        start = 1'b0;
        take_req("reqC", 64'h100);
        for (int i = 0; i < 16; i++) prog[i] = 32'h0;
        prog[0] = movz(1, 16'h4000, 3);
        prog[1] = movz(9, 3, 0);
        prog[2] = adds(10, 31, 9, 4);
        prog[3] = adds(31, 1, 1, 0);
        prog[4] = 32'h0;
        prog[5] = HLT;
        push_dump(64'h0, 64'h4000_0000_0000_0000, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0);
        send_line("ready_C", 64'h100, pack(prog));
        run_serve(20);
        chk("C_x1", dut.r_regs[1], 64'h4000_0000_0000_0000);
        chk("C_x9", dut.r_regs[9], 64'd3);
        chk("C_x10", dut.r_regs[10], 64'h30);
        chk("C_nzcv", dut.r_nzcv, 4'b1001);
        chk("C_pc_at_hlt", dut.r_pc, 64'h114);
        check_halt("C");

        chk("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
